// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM arbiter.
package sdram_arb_pkg;

    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RECOVER = 2'd3
    } arb_state_t;

    // The watchdog counts 0..timeout-1 and needs at least one bit.
    function automatic int wd_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Two-way round-robin picker: a lone requester wins; on a tie the port that
// did not finish last wins.
module sdram_rr_pick (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~rr_last : req[1];
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one single-word SDRAM controller between two requesters, with
// round-robin arbitration, a per-access watchdog and timeout recovery.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate and latch the winning command
// ISSUE   | one-cycle strobe to the controller, gnt pulsed to the owner
// WAIT    | waiting for mem_ack; watchdog bounds the wait
// RECOVER | after a timeout, TIMEOUT cycles of discarding stray acks
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int              WD_W    = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t      state;
    logic            rr_last;
    logic            owner;
    logic [WD_W-1:0] watchdog;
    logic            pick_valid;
    logic            pick_winner;

    sdram_rr_pick u_pick (
        .req     ({p1_req, p0_req}),
        .rr_last (rr_last),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_last   <= 1'b1;
            owner     <= 1'b0;
            watchdog  <= '0;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_cnt   <= 8'd0;
        end else begin
            p0_gnt  <= 1'b0;
            p1_gnt  <= 1'b0;
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            p0_err  <= 1'b0;
            p1_err  <= 1'b0;
            mem_req <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // mem_ack is ignored here: nothing is outstanding.
                    if (pick_valid) begin
                        owner     <= pick_winner;
                        mem_we    <= pick_winner ? p1_we    : p0_we;
                        mem_addr  <= pick_winner ? p1_addr  : p0_addr;
                        mem_wdata <= pick_winner ? p1_wdata : p0_wdata;
                        p0_gnt    <= ~pick_winner;
                        p1_gnt    <= pick_winner;
                        mem_req   <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    watchdog <= '0;
                    state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (mem_ack) begin
                        if (owner) begin
                            p1_done <= 1'b1;
                            if (!mem_we) p1_rdata <= mem_rdata;
                        end else begin
                            p0_done <= 1'b1;
                            if (!mem_we) p0_rdata <= mem_rdata;
                        end
                        rr_last <= owner;
                        state   <= ST_IDLE;
                    end else if (watchdog == WD_LAST) begin
                        if (owner) begin
                            p1_done <= 1'b1;
                            p1_err  <= 1'b1;
                        end else begin
                            p0_done <= 1'b1;
                            p0_err  <= 1'b1;
                        end
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        rr_last  <= owner;
                        watchdog <= '0;
                        state    <= ST_RECOVER;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end

                ST_RECOVER: begin
                    // A late ack from the aborted access is dropped here.
                    if (watchdog == WD_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and memory.
module tb_sdram_port_arbiter;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              p0_req, p0_we, p0_gnt, p0_done, p0_err;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_gnt, p1_done, p1_err;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic              mem_req, mem_we, mem_ack, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [7:0]        err_cnt;

    int checks   = 0;
    int failures = 0;

    logic              pend      [2];
    logic              cmd_we    [2];
    logic [ADDR_W-1:0] cmd_addr  [2];
    logic [DATA_W-1:0] cmd_wdata [2];
    logic [DATA_W-1:0] exp_rdata [2];
    int                last_owner;
    int                exp_err_cnt;
    logic [DATA_W-1:0] mem_model [logic [ADDR_W-1:0]];

    assign p0_req   = pend[0];
    assign p0_we    = cmd_we[0];
    assign p0_addr  = cmd_addr[0];
    assign p0_wdata = cmd_wdata[0];
    assign p1_req   = pend[1];
    assign p1_we    = cmd_we[1];
    assign p1_addr  = cmd_addr[1];
    assign p1_wdata = cmd_wdata[1];

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? p0_gnt : p1_gnt;
    endfunction
    function automatic logic done_of(input int p);
        return (p == 0) ? p0_done : p1_done;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 0) ? p0_err : p1_err;
    endfunction
    function automatic logic [DATA_W-1:0] rdata_of(input int p);
        return (p == 0) ? p0_rdata : p1_rdata;
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (!mem_model.exists(a)) mem_model[a] = DATA_W'($urandom);
        return mem_model[a];
    endfunction

    task automatic new_cmd(input int p);
        cmd_we[p]    = 1'($urandom_range(0, 1));
        cmd_addr[p]  = ADDR_W'($urandom_range(0, 31));
        cmd_wdata[p] = DATA_W'($urandom);
    endtask

    task automatic check_rdata_held(input string tag);
        chk({tag, "_p0_rdata"}, p0_rdata, exp_rdata[0]);
        chk({tag, "_p1_rdata"}, p1_rdata, exp_rdata[1]);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("rst_gnt",   {p0_gnt, p1_gnt}, 0);
        chk("rst_done",  {p0_done, p1_done}, 0);
        chk("rst_err",   {p0_err, p1_err}, 0);
        chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
        chk("rst_mem",   {mem_req, mem_we, mem_addr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_errcnt", err_cnt, 0);
        repeat (2) @(negedge clk);
        reset        = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_owner   = 1;
        exp_err_cnt  = 0;
    endtask

    // Waits for the strobe; n = cycles from the call until gnt was seen.
    task automatic wait_grant(input int p, output int n);
        bit seen = 0;
        n = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (mem_req) seen = 1;
        end
        chk("grant_seen", 32'(seen), 1);
        if (seen) begin
            chk("gnt_owner", gnt_of(p), 1);
            chk("gnt_other", gnt_of(1 - p), 0);
            chk("mem_we", mem_we, cmd_we[p]);
            chk("mem_addr", mem_addr, cmd_addr[p]);
            chk("mem_wdata", mem_wdata, cmd_wdata[p]);
            chk("busy_issue", busy, 1);
        end
    endtask

    // Controller model: ack lat cycles after the strobe cycle.
    task automatic serve(input int p, input int lat, input bit keep);
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd, rd;
        we = cmd_we[p];
        a  = cmd_addr[p];
        wd = cmd_wdata[p];
        if (!keep) pend[p] = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            chk("strobe_once", mem_req, 0);
            chk("gnt_once", {p0_gnt, p1_gnt}, 0);
            chk("early_done", {p0_done, p1_done}, 0);
            chk("busy_wait", busy, 1);
        end
        rd        = we ? DATA_W'($urandom) : model_read(a);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = DATA_W'($urandom);
        chk("done_owner", done_of(p), 1);
        chk("err_owner", err_of(p), 0);
        chk("done_other", done_of(1 - p), 0);
        if (we) mem_model[a] = wd;
        else    exp_rdata[p] = rd;
        check_rdata_held("done");
        chk("mem_addr_stable", mem_addr, a);
        chk("mem_we_stable", mem_we, we);
        last_owner = p;
    endtask

    task automatic timeout_access(input int p, input bit inject, input bit req_other);
        pend[p] = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            chk("to_no_done", {p0_done, p1_done}, 0);
            chk("to_busy", busy, 1);
        end
        @(negedge clk);
        chk("to_done", done_of(p), 1);
        chk("to_err", err_of(p), 1);
        chk("to_done_other", done_of(1 - p), 0);
        exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
        chk("to_err_cnt", err_cnt, exp_err_cnt);
        check_rdata_held("to");
        last_owner = p;
        for (int i = 1; i < TIMEOUT; i++) begin
            @(negedge clk);
            chk("rec_busy", busy, 1);
            chk("rec_no_gnt", {p0_gnt, p1_gnt}, 0);
            chk("rec_no_done", {p0_done, p1_done}, 0);
            if (req_other && i == 1) begin
                new_cmd(1 - p);
                pend[1 - p] = 1'b1;
            end
            if (inject && i == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = DATA_W'($urandom);
            end
            if (inject && i == 3) mem_ack = 1'b0;
        end
        @(negedge clk);
        chk("rec_exit_idle", busy, 0);
        chk("rec_exit_no_gnt", {p0_gnt, p1_gnt}, 0);
        chk("rec_exit_no_done", {p0_done, p1_done}, 0);
        check_rdata_held("rec");
    endtask

    initial begin
        int n;
        int exp_p;
        reset     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int p = 0; p < 2; p++) begin
            pend[p]      = 1'b0;
            cmd_we[p]    = 1'b0;
            cmd_addr[p]  = '0;
            cmd_wdata[p] = '0;
            exp_rdata[p] = '0;
        end
        last_owner  = 1;
        exp_err_cnt = 0;
        #2;
        do_reset();

        // Ack while idle is ignored.
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_done", {p0_done, p1_done}, 0);
        chk("idle_ack_busy", busy, 0);
        check_rdata_held("idle_ack");

        // Single write from port 0, ack three cycles after the strobe.
        cmd_we[0] = 1'b1; cmd_addr[0] = 24'h000001; cmd_wdata[0] = 16'hA5A5;
        pend[0] = 1'b1;
        wait_grant(0, n);
        chk("write_lat", n, 1);
        serve(0, 3, 0);

        // Read from port 1, then a write that must leave p1_rdata alone.
        mem_model[24'h00ABCD] = 16'h1234;
        cmd_we[1] = 1'b0; cmd_addr[1] = 24'h00ABCD; cmd_wdata[1] = 16'h0;
        pend[1] = 1'b1;
        wait_grant(1, n);
        serve(1, 2, 0);
        chk("read_rdata", p1_rdata, 16'h1234);
        cmd_we[1] = 1'b1; cmd_addr[1] = 24'h000020; cmd_wdata[1] = 16'h5555;
        pend[1] = 1'b1;
        wait_grant(1, n);
        serve(1, 4, 0);
        chk("read_rdata_held", p1_rdata, 16'h1234);
        chk("p0_rdata_untouched", p0_rdata, 16'h0);

        // Both ports requesting continuously from reset alternate 0,1,0,1.
        do_reset();
        new_cmd(0);
        new_cmd(1);
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(k % 2, n);
            chk("fair_lat", n, 1);
            serve(k % 2, 2, 1);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;

        // Timeout with a late ack in recovery and port 1 waiting.
        @(negedge clk);
        new_cmd(0);
        pend[0] = 1'b1;
        wait_grant(0, n);
        timeout_access(0, 1, 1);
        wait_grant(1, n);
        chk("after_recover_lat", n, 1);
        serve(1, 2, 0);

        // Reset two cycles after the strobe abandons the access.
        new_cmd(0);
        pend[0] = 1'b1;
        wait_grant(0, n);
        pend[0] = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abandon_no_done", {p0_done, p1_done}, 0);
            chk("abandon_idle", busy, 0);
        end
        new_cmd(0);
        new_cmd(1);
        pend[0] = 1'b1;
        pend[1] = 1'b1;
        wait_grant(0, n);
        serve(0, 2, 0);
        wait_grant(1, n);
        chk("post_reset_second_lat", n, 1);
        serve(1, 1, 0);

        // Random traffic: winner predicted from the round-robin rule.
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    new_cmd(p);
                    pend[p] = 1'b1;
                end
            end
            if (!pend[0] && !pend[1]) begin
                exp_p = int'($urandom_range(0, 1));
                new_cmd(exp_p);
                pend[exp_p] = 1'b1;
            end
            exp_p = (pend[0] && pend[1]) ? 1 - last_owner : (pend[0] ? 0 : 1);
            wait_grant(exp_p, n);
            chk("rand_lat", n, 1);
            serve(exp_p, int'($urandom_range(1, 5)), 0);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;

        // Saturation of the timeout counter.
        do_reset();
        for (int k = 0; k < 260; k++) begin
            new_cmd(0);
            pend[0] = 1'b1;
            wait_grant(0, n);
            timeout_access(0, 0, 0);
        end
        chk("err_cnt_saturated", err_cnt, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
